// File: rtl/mem_responder_pkg.sv
// Shared memory-bus encodings and load/store lane helpers for the core and its responder.
package mem_responder_pkg;

  localparam logic [1:0] MEM_B   = 2'b00;
  localparam logic [1:0] MEM_H   = 2'b01;
  localparam logic [1:0] MEM_W   = 2'b10;
  localparam logic [1:0] MEM_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } resp_state_t;

  // Pick the addressed lane out of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  mtype,
                                               input logic        sign);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (mtype)
      MEM_B:   res = {{24{b[7] & sign}}, b};
      MEM_H:   res = {{16{h[15] & sign}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] mtype, input logic [1:0] lane);
    logic [3:0] be;
    case (mtype)
      MEM_B:   be = 4'b0001 << lane;
      MEM_H:   be = lane[1] ? 4'b1100 : 4'b0011;
      MEM_W:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_responder_bram_be.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables and one-cycle read latency.
module bram_be #(
  parameter int    ADDR_WIDTH = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [3:0]            i_be,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-bus slave: byte/half/word loads and stores on a byte-enable RAM with a ready/err handshake.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_type,
  input  logic        mem_sign,
  input  logic        rmem,
  input  logic        wmem,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam logic [32:0] SPAN = 33'd4 << ADDR_WIDTH;

  resp_state_t r_state, w_state_next;
  logic [1:0]  r_lane;
  logic [1:0]  r_type;
  logic        r_sign;
  logic [31:0] r_rdata;

  logic [31:0] w_offset;
  logic        w_in_range;
  logic        w_misalign;
  logic        w_err;
  logic        w_accept;
  logic        w_we;
  logic        w_re;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_ram_rdata;

  // Addresses below the base wrap to huge offsets and fall out of range.
  assign w_offset   = mem_addr - BASE_ADDR;
  assign w_in_range = ({1'b0, w_offset} < SPAN);

  always_comb begin
    w_misalign = 1'b0;
    case (mem_type)
      MEM_H:   w_misalign = mem_addr[0];
      MEM_W:   w_misalign = (mem_addr[1:0] != 2'b00);
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_err    = (rmem && wmem) || (mem_type == MEM_RSV) || w_misalign || !w_in_range;
  assign w_accept = (r_state == ST_IDLE) && (rmem || wmem);
  assign w_we     = w_accept && wmem && !w_err && !rst;
  assign w_re     = w_accept && rmem && !w_err && !rst;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign w_wdata_rep[8*gi +: 8] = (mem_type == MEM_B) ? mem_wdata[7:0] :
                                    (mem_type == MEM_H) ? mem_wdata[8*(gi%2) +: 8] :
                                                          mem_wdata[8*gi +: 8];
  end

  bram_be #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_be    (store_be(mem_type, mem_addr[1:0])),
    .i_re    (w_re),
    .i_addr  (w_offset[ADDR_WIDTH+1:2]),
    .i_wdata (w_wdata_rep),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (rmem || wmem) begin
          if (w_err)     w_state_next = ST_ERR;
          else if (rmem) w_state_next = ST_RD;
          else           w_state_next = ST_RESP;
        end
      end
      ST_RD:   w_state_next = ST_RESP;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane <= 2'b00;
      r_type <= MEM_B;
      r_sign <= 1'b0;
    end else if (w_accept) begin
      r_lane <= mem_addr[1:0];
      r_type <= mem_type;
      r_sign <= mem_sign;
    end
  end

  // Load data only changes when a read leaves RD; a reset discards it.
  always_ff @(posedge clk) begin
    if (rst)                    r_rdata <= 32'h0;
    else if (r_state == ST_RD)  r_rdata <= load_extract(w_ram_rdata, r_lane, r_type, r_sign);
  end

  assign mem_rdata = r_rdata;
  assign mem_ready = (r_state == ST_RESP) || (r_state == ST_ERR);
  assign mem_err   = (r_state == ST_ERR);

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized checks of mem_responder against a byte-array memory model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          SPAN_BYTES = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_type;
  logic        mem_sign;
  logic        rmem;
  logic        wmem;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem_b [0:SPAN_BYTES-1];
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_WIDTH (12),
    .BASE_ADDR  (BASE),
    .INIT_FILE  ("")
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_type  (mem_type),
    .mem_sign  (mem_sign),
    .rmem      (rmem),
    .wmem      (wmem),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_err   (mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic r, input logic w, input logic [31:0] addr,
                                     input logic [1:0] typ);
    logic [31:0] off;
    off = addr - BASE;
    if (r && w) return 1'b1;
    if (typ == 2'd3) return 1'b1;
    if (typ == 2'd1 && (addr % 2) != 0) return 1'b1;
    if (typ == 2'd2 && (addr % 4) != 0) return 1'b1;
    if (off >= SPAN_BYTES) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [1:0] typ,
                                             input logic sgn);
    int off;
    off = int'(addr - BASE);
    case (typ)
      2'd0: return sgn ? 32'($signed(mem_b[off])) : 32'(mem_b[off]);
      2'd1: return sgn ? 32'($signed({mem_b[off+1], mem_b[off]}))
                       : 32'({mem_b[off+1], mem_b[off]});
      default: return {mem_b[off+3], mem_b[off+2], mem_b[off+1], mem_b[off]};
    endcase
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] typ);
    int off;
    int nbytes;
    off = int'(addr - BASE);
    nbytes = (typ == 2'd0) ? 1 : (typ == 2'd1) ? 2 : 4;
    for (int i = 0; i < nbytes; i++) mem_b[off+i] = wd[8*i +: 8];
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic txn(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [1:0] typ, input logic sgn);
    logic e;
    int   lat;
    int   exp_lat;
    logic got;
    e = model_err(r, w, addr, typ);
    exp_lat = (!e && r) ? 2 : 1;
    mem_addr = addr; mem_wdata = wd; mem_type = typ; mem_sign = sgn;
    rmem = r; wmem = w;
    @(posedge clk);
    #1;
    rmem = 1'b0; wmem = 1'b0;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = mem_ready;
    end
    if (!got) lat = 99;
    if (!e && r) exp_rdata = model_read(addr, typ, sgn);
    if (!e && w) model_write(addr, wd, typ);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("err", 32'(mem_err), 32'(e));
    chk("rdata", mem_rdata, exp_rdata);
    $display("txn r=%0b w=%0b addr=%h wdata=%h type=%0d sign=%0b -> lat=%0d err=%0b rdata=%h",
             r, w, addr, wd, typ, sgn, lat, mem_err, mem_rdata);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  t;
    int          k;
    int          sel;

    rst = 1'b1; rmem = 1'b0; wmem = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0; mem_type = 2'b00; mem_sign = 1'b0;
    exp_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(mem_ready), 32'h0);
    chk("rst_err", 32'(mem_err), 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Word store/load and sign handling
    txn(0, 1, BASE + 32'h10, 32'hDEADBEEF, MEM_W, 0);
    txn(1, 0, BASE + 32'h10, 32'h0, MEM_W, 0);
    chk("plan_word", mem_rdata, 32'hDEADBEEF);
    txn(1, 0, BASE + 32'h13, 32'h0, MEM_B, 1);
    chk("plan_byte_s", mem_rdata, 32'hFFFFFFDE);
    txn(1, 0, BASE + 32'h13, 32'h0, MEM_B, 0);
    chk("plan_byte_u", mem_rdata, 32'h000000DE);
    txn(1, 0, BASE + 32'h10, 32'h0, MEM_H, 1);
    chk("plan_half_s", mem_rdata, 32'hFFFFBEEF);

    // Sub-word store merge
    txn(0, 1, BASE + 32'h11, 32'h0000005A, MEM_B, 0);
    txn(1, 0, BASE + 32'h10, 32'h0, MEM_W, 0);
    chk("plan_merge_b", mem_rdata, 32'hDEAD5AEF);
    txn(0, 1, BASE + 32'h12, 32'h00001234, MEM_H, 0);
    txn(1, 0, BASE + 32'h10, 32'h0, MEM_W, 0);
    chk("plan_merge_h", mem_rdata, 32'h12345AEF);

    // Error completions leave memory and rdata alone
    txn(0, 1, BASE + 32'h14, 32'hCAFEF00D, MEM_W, 0);
    txn(1, 0, BASE + 32'h01, 32'h0, MEM_H, 0);
    txn(0, 1, BASE + 32'h16, 32'h11111111, MEM_W, 0);
    txn(1, 0, BASE + 32'h10, 32'h0, MEM_RSV, 0);
    txn(1, 1, BASE + 32'h10, 32'h22222222, MEM_W, 0);
    txn(1, 0, BASE + 32'h4000, 32'h0, MEM_W, 0);
    txn(0, 1, BASE - 32'h4, 32'h33333333, MEM_W, 0);
    chk("err_rdata_kept", mem_rdata, 32'h12345AEF);
    txn(1, 0, BASE + 32'h14, 32'h0, MEM_W, 0);
    chk("err_no_store", mem_rdata, 32'hCAFEF00D);
    txn(1, 0, BASE + 32'h10, 32'h0, MEM_W, 0);
    chk("err_no_store2", mem_rdata, 32'h12345AEF);

    // Back-to-back: strobe held, one accept per IDLE
    mem_addr = BASE + 32'h10; mem_type = MEM_W; mem_sign = 1'b0; rmem = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("b2b_ready_c%0d", c), 32'(mem_ready), ((c == 2) || (c == 5)) ? 32'h1 : 32'h0);
      if (c == 2 || c == 5) chk($sformatf("b2b_rdata_c%0d", c), mem_rdata, 32'h12345AEF);
    end
    rmem = 1'b0;
    $display("txn back-to-back read addr=%h rdata=%h", BASE + 32'h10, mem_rdata);
    @(negedge clk);

    // Reset during RD discards the read
    mem_addr = BASE + 32'h14; mem_type = MEM_W; rmem = 1'b1;
    @(posedge clk);
    #1 rmem = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_rdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rstrd_ready", 32'(mem_ready), 32'h0);
      chk("rstrd_rdata", mem_rdata, 32'h0);
    end
    $display("txn read aborted by reset rdata=%h", mem_rdata);

    // Write with reset in its accept cycle is not committed
    mem_addr = BASE + 32'h10; mem_wdata = 32'h0BADF00D; mem_type = MEM_W;
    wmem = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1 wmem = 1'b0; rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rstwr_ready", 32'(mem_ready), 32'h0);
    end
    $display("txn write aborted by reset addr=%h", BASE + 32'h10);
    txn(1, 0, BASE + 32'h10, 32'h0, MEM_W, 0);
    chk("rstwr_unchanged", mem_rdata, 32'h12345AEF);

    // Randomized traffic over a 64-byte window plus out-of-range probes
    for (int i = 0; i < 16; i++) txn(0, 1, BASE + 32'(4*i), $urandom, MEM_W, 0);
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = BASE + 32'($urandom_range(0, 63));
      else if (sel == 8) a = BASE + 32'h4000 + 32'($urandom_range(0, 15));
      else               a = BASE - 32'($urandom_range(1, 8));
      t = (($urandom % 8) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      k = $urandom_range(0, 19);
      if (k == 0)      txn(1, 1, a, $urandom, t, 1'($urandom));
      else if (k < 10) txn(1, 0, a, $urandom, t, 1'($urandom));
      else             txn(0, 1, a, $urandom, t, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
